// File: rtl/id_stage_buffered_pkg.sv
// Shared opcode map, opcode-class helpers and the default-width decoded packet layout.
package id_pkg;

  localparam int OPC_FN_W = 8;

  localparam logic [4:0] OP_MOV            = 5'd0;
  localparam logic [4:0] OP_ADD            = 5'd1;
  localparam logic [4:0] OP_SUB            = 5'd2;
  localparam logic [4:0] OP_AND            = 5'd3;
  localparam logic [4:0] OP_OR             = 5'd4;
  localparam logic [4:0] OP_NOT            = 5'd5;
  localparam logic [4:0] OP_CMP            = 5'd6;
  localparam logic [4:0] OP_MULT           = 5'd7;
  localparam logic [4:0] OP_DIV            = 5'd8;
  localparam logic [4:0] OP_OB_CHECK       = 5'd9;
  localparam logic [4:0] OP_VELOCITY_GUARD = 5'd10;
  localparam logic [4:0] OP_MOVE_LEFT      = 5'd11;
  localparam logic [4:0] OP_MOVE_RIGHT     = 5'd12;
  localparam logic [4:0] OP_STOP           = 5'd13;
  localparam logic [4:0] OP_CONTINUE       = 5'd14;

  // Helpers take a zero-extended opcode so any OPC_W up to OPC_FN_W decodes correctly.
  function automatic logic is_alu(input logic [OPC_FN_W-1:0] opc);
    return opc <= OPC_FN_W'(OP_VELOCITY_GUARD);
  endfunction

  function automatic logic is_motion(input logic [OPC_FN_W-1:0] opc);
    return (opc >= OPC_FN_W'(OP_MOVE_LEFT)) && (opc <= OPC_FN_W'(OP_CONTINUE));
  endfunction

  function automatic logic is_writer(input logic [OPC_FN_W-1:0] opc);
    return (opc <= OPC_FN_W'(OP_DIV)) && (opc != OPC_FN_W'(OP_CMP));
  endfunction

  typedef struct packed {
    logic [15:0] op_b;
    logic [15:0] op_a;
    logic [4:0]  opcode;
    logic [3:0]  rd;
  } id_pkt_t;

endpackage

// File: rtl/id_stage_buffered_out_fifo.sv
// DEPTH-entry synchronous output FIFO; flush empties it and overrides a same-cycle pop.
module id_out_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PTR_W-1:0]        wr_q, rd_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (flush_i) cnt_d = '0;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push_i) begin
          mem_q[wr_q] <= din_i;
          wr_q        <= wr_q + 1'b1;
        end
        if (pop_i) rd_q <= rd_q + 1'b1;
      end
    end
  end

  assign dout_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/id_stage_buffered.sv
// Buffered decode stage: field split, regfile operand capture, output queue, illegal-op pulse.
// Optional RAW interlock scoreboard enabled by defining ID_SCOREBOARD_EN.
module id_stage_buffered import id_pkg::*; #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 5,
  parameter int RA_W    = 4,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [INSTR_W-1:0]             in_instr,
  input  logic                           in_req,
  output logic                           in_ack,
  output logic [RA_W-1:0]                rsone,
  output logic [RA_W-1:0]                rstwo,
  input  logic [DATA_W-1:0]              reg_out_A,
  input  logic [DATA_W-1:0]              reg_out_B,
  output logic [2*DATA_W+OPC_W+RA_W-1:0] out_data,
  output logic                           out_req,
  input  logic                           out_ack,
  input  logic                           wb_valid,
  input  logic [RA_W-1:0]                wb_rd,
  output logic                           illegal_op,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);
  localparam int PKT_W = 2*DATA_W + OPC_W + RA_W;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [OPC_W-1:0]    opc;
  logic [OPC_FN_W-1:0] opc_x;
  logic [RA_W-1:0]     rd, rs1, rs2;
  logic                alu, motion, writer, legal;
  logic                full, hazard, accept, push, pop;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [PKT_W-1:0]    pkt;
  logic                illegal_q;
  logic                unused_lo;

  assign opc    = in_instr[INSTR_W-1 -: OPC_W];
  assign rd     = in_instr[INSTR_W-OPC_W-1 -: RA_W];
  assign rs1    = in_instr[INSTR_W-OPC_W-RA_W-1 -: RA_W];
  assign rs2    = in_instr[INSTR_W-OPC_W-2*RA_W-1 -: RA_W];
  assign unused_lo = ^in_instr[INSTR_W-OPC_W-3*RA_W-1:0];
  assign rsone  = rs1;
  assign rstwo  = rs2;

  assign opc_x  = OPC_FN_W'(opc);
  assign alu    = is_alu(opc_x);
  assign motion = is_motion(opc_x);
  assign writer = is_writer(opc_x);
  assign legal  = alu | motion;

  // in_ack looks only at registered occupancy, never at out_ack.
  assign full   = (occupancy == CNT_W'(DEPTH));
  assign in_ack = !full && !flush && !hazard;
  assign accept = in_req && in_ack;
  assign push   = accept && legal;
  assign pop    = out_req && out_ack;

  assign op_a = alu ? reg_out_A : '0;
  assign op_b = alu ? reg_out_B : '0;
  assign pkt  = {op_b, op_a, opc, rd};

`ifdef ID_SCOREBOARD_EN
  logic [2**RA_W-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (wb_valid) pend_d[wb_rd] = 1'b0;
    if (accept && writer) pend_d[rd] = 1'b1;
    if (flush) pend_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign hazard = (alu && (pend_q[rs1] || pend_q[rs2])) || (writer && pend_q[rd]);
`else
  logic unused_wb;
  assign unused_wb = wb_valid ^ (^wb_rd) ^ writer;
  assign hazard    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= accept && !legal;
  end
  assign illegal_op = illegal_q;

  id_out_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (pkt),
    .pop_i   (pop),
    .flush_i (flush),
    .dout_o  (out_data),
    .count_o (occupancy)
  );

  assign out_req = (occupancy != '0);

endmodule

// File: tb/tb_id_stage_buffered.sv
// Directed bench for id_stage_buffered: vector table plus backpressure, flush, hazard and streaming sequences.
`timescale 1ns/1ps
module tb_id_stage_buffered;
  import id_pkg::*;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 5;
  localparam int RA_W    = 4;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 2;
  localparam int PKT_W   = 2*DATA_W + OPC_W + RA_W;

  logic               clk = 1'b0;
  logic               reset, flush, in_req, out_ack, wb_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ack, out_req, illegal_op;
  logic [RA_W-1:0]    rsone, rstwo, wb_rd;
  logic [DATA_W-1:0]  reg_a, reg_b;
  logic [PKT_W-1:0]   out_data;
  logic [1:0]         occupancy;

  int checks   = 0;
  int failures = 0;

  id_stage_buffered #(.INSTR_W(INSTR_W), .OPC_W(OPC_W), .RA_W(RA_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_instr(in_instr), .in_req(in_req), .in_ack(in_ack),
    .rsone(rsone), .rstwo(rstwo), .reg_out_A(reg_a), .reg_out_B(reg_b), .out_data(out_data),
    .out_req(out_req), .out_ack(out_ack), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .illegal_op(illegal_op), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [4:0] opc, input logic [3:0] rd,
                                                  input logic [3:0] r1, input logic [3:0] r2);
    return {opc, rd, r1, r2, 15'h5a5a};
  endfunction

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [15:0] b, input logic [15:0] a,
                                              input logic [4:0] opc, input logic [3:0] rd);
    id_pkt_t p;
    p.op_b = b; p.op_a = a; p.opcode = opc; p.rd = rd;
    return p;
  endfunction

  task automatic drive(input logic [4:0] opc, input logic [3:0] rd, input logic [3:0] r1,
                       input logic [3:0] r2, input logic [15:0] a, input logic [15:0] b);
    in_instr = mk_instr(opc, rd, r1, r2);
    reg_a    = a;
    reg_b    = b;
  endtask

  typedef struct {
    logic [4:0]  opc;
    logic [3:0]  rd, rs1, rs2;
    logic [15:0] a, b;
    logic        legal;
    logic [15:0] ea, eb;
  } vec_t;

  vec_t vt[8];
  logic [PKT_W-1:0] mq[$];
  logic [PKT_W-1:0] np;

  task automatic rnd_beat(output logic [PKT_W-1:0] p);
    logic [4:0]  o;
    logic [3:0]  d, r1, r2;
    logic [15:0] a, b;
`ifdef ID_SCOREBOARD_EN
    case ($urandom_range(0, 2))
      0:       o = OP_CMP;
      1:       o = OP_OB_CHECK;
      default: o = OP_VELOCITY_GUARD;
    endcase
`else
    o = 5'($urandom_range(0, 10));
`endif
    d  = 4'($urandom);
    r1 = 4'($urandom);
    r2 = 4'($urandom);
    a  = 16'($urandom);
    b  = 16'($urandom);
    drive(o, d, r1, r2, a, b);
    p = mk_pkt(b, a, o, d);
  endtask

  initial begin
    vt[0] = '{OP_ADD,            4'd3,  4'd1,  4'd2,  16'h0011, 16'h0022, 1'b1, 16'h0011, 16'h0022};
    vt[1] = '{OP_SUB,            4'd15, 4'd0,  4'd7,  16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'h0001};
    vt[2] = '{OP_STOP,           4'd2,  4'd4,  4'd5,  16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000};
    vt[3] = '{OP_MOVE_LEFT,      4'd9,  4'd10, 4'd11, 16'h1234, 16'h5678, 1'b1, 16'h0000, 16'h0000};
    vt[4] = '{OP_VELOCITY_GUARD, 4'd0,  4'd12, 4'd13, 16'hABCD, 16'h0000, 1'b1, 16'hABCD, 16'h0000};
    vt[5] = '{5'd31,             4'd1,  4'd2,  4'd4,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000};
    vt[6] = '{5'd15,             4'd6,  4'd7,  4'd8,  16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h0000};
    vt[7] = '{OP_CMP,            4'd4,  4'd6,  4'd8,  16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE};

    reset = 1'b1; flush = 1'b0; in_req = 1'b0; out_ack = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    in_instr = '0; reg_a = '0; reg_b = '0;
    #12;
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    reset = 1'b0;
    tick();

    // Vector table: one beat each, then regfile is scrambled before the packet is checked.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].opc, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].a, vt[i].b);
      in_req = 1'b1;
      #2;
      chk("vec_in_ack", 64'(in_ack), 64'd1);
      chk("vec_rsone", 64'(rsone), 64'(vt[i].rs1));
      chk("vec_rstwo", 64'(rstwo), 64'(vt[i].rs2));
      tick();
      in_req = 1'b0; reg_a = ~vt[i].a; reg_b = ~vt[i].b;
      #2;
      if (vt[i].legal) begin
        chk("vec_out_req", 64'(out_req), 64'd1);
        chk("vec_out_data", 64'(out_data), 64'(mk_pkt(vt[i].eb, vt[i].ea, vt[i].opc, vt[i].rd)));
        chk("vec_no_illegal", 64'(illegal_op), 64'd0);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        #2;
        chk("vec_popped", 64'(occupancy), 64'd0);
      end else begin
        chk("ill_pulse", 64'(illegal_op), 64'd1);
        chk("ill_occ", 64'(occupancy), 64'd0);
        tick();
        #2;
        chk("ill_pulse_end", 64'(illegal_op), 64'd0);
      end
    end

    // Backpressure: third beat refused while full, even with a pop pending.
    drive(OP_OB_CHECK, 4'd1, 4'd2, 4'd4, 16'h0101, 16'h1010);
    in_req = 1'b1; #2;
    chk("bp_ack0", 64'(in_ack), 64'd1);
    tick();
    drive(OP_OB_CHECK, 4'd1, 4'd2, 4'd4, 16'h0202, 16'h2020); #2;
    chk("bp_ack1", 64'(in_ack), 64'd1);
    tick();
    drive(OP_OB_CHECK, 4'd1, 4'd2, 4'd4, 16'h0303, 16'h3030); #2;
    chk("bp_full_refuse", 64'(in_ack), 64'd0);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_head0", 64'(out_data), 64'(mk_pkt(16'h1010, 16'h0101, OP_OB_CHECK, 4'd1)));
    out_ack = 1'b1; #2;
    chk("bp_full_pop_refuse", 64'(in_ack), 64'd0);
    tick(); #2;
    chk("bp_occ1", 64'(occupancy), 64'd1);
    chk("bp_head1", 64'(out_data), 64'(mk_pkt(16'h2020, 16'h0202, OP_OB_CHECK, 4'd1)));
    chk("bp_ack2", 64'(in_ack), 64'd1);
    tick();
    in_req = 1'b0; #2;
    chk("bp_occ_pushpop", 64'(occupancy), 64'd1);
    chk("bp_head2", 64'(out_data), 64'(mk_pkt(16'h3030, 16'h0303, OP_OB_CHECK, 4'd1)));
    tick();
    out_ack = 1'b0; #2;
    chk("bp_drained", 64'(out_req), 64'd0);

    // Flush with a simultaneous pop on a full queue.
    drive(OP_CMP, 4'd2, 4'd1, 4'd1, 16'hAAAA, 16'h5555);
    in_req = 1'b1; tick(); tick();
    drive(OP_CMP, 4'd3, 4'd1, 4'd1, 16'hBEEF, 16'hCAFE);
    flush = 1'b1; out_ack = 1'b1; #2;
    chk("fl_in_ack", 64'(in_ack), 64'd0);
    tick();
    flush = 1'b0; out_ack = 1'b0; in_req = 1'b0; #2;
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_out_req", 64'(out_req), 64'd0);
    chk("fl_out_data", 64'(out_data), 64'd0);
    in_req = 1'b1; tick();
    in_req = 1'b0; #2;
    chk("fl_new_occ", 64'(occupancy), 64'd1);
    chk("fl_new_head", 64'(out_data), 64'(mk_pkt(16'hCAFE, 16'hBEEF, OP_CMP, 4'd3)));
    out_ack = 1'b1; tick();
    out_ack = 1'b0; #2;
    chk("fl_new_popped", 64'(occupancy), 64'd0);

`ifdef ID_SCOREBOARD_EN
    out_ack = 1'b1;
    drive(OP_MOV, 4'd5, 4'd1, 4'd2, 16'h0001, 16'h0002);
    in_req = 1'b1; tick();
    drive(OP_ADD, 4'd6, 4'd5, 4'd1, 16'h0003, 16'h0004); #2;
    chk("sb_stall0", 64'(in_ack), 64'd0);
    tick(); #2;
    chk("sb_stall1", 64'(in_ack), 64'd0);
    wb_valid = 1'b1; wb_rd = 4'd5; #2;
    chk("sb_stall_wb_cycle", 64'(in_ack), 64'd0);
    tick();
    wb_valid = 1'b0; #2;
    chk("sb_release", 64'(in_ack), 64'd1);
    tick();
    in_req = 1'b0; #2;
    chk("sb_add_head", 64'(out_data), 64'(mk_pkt(16'h0004, 16'h0003, OP_ADD, 4'd6)));
    tick();
    out_ack = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; #2;
`endif

    // Streaming: one entry primed, then push+pop every cycle.
    rnd_beat(np);
    in_req = 1'b1; tick();
    mq.push_back(np);
    out_ack = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rnd_beat(np); #2;
      chk("st_in_ack", 64'(in_ack), 64'd1);
      chk("st_occ", 64'(occupancy), 64'd1);
      chk("st_data", 64'(out_data), 64'(mq[0]));
      tick();
      void'(mq.pop_front());
      mq.push_back(np);
    end
    in_req = 1'b0; #2;
    chk("st_last", 64'(out_data), 64'(mq[0]));
    tick();
    out_ack = 1'b0; #2;
    chk("st_empty", 64'(occupancy), 64'd0);

    // Reset with an entry queued and a beat in flight.
    drive(OP_AND, 4'd7, 4'd8, 4'd9, 16'h0F0F, 16'hF0F0);
    in_req = 1'b1; tick(); #2;
    reset = 1'b1; #2;
    chk("rst_mid_occ", 64'(occupancy), 64'd0);
    chk("rst_mid_data", 64'(out_data), 64'd0);
    in_req = 1'b0; tick();
    reset = 1'b0; tick(); #2;
    chk("rst_mid_after", 64'(out_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
